operand_entry: RTL

- Input front-end for the ALU lab top level. Debounces the two push buttons and uses them with the switch bank to load the 16-bit ALU operands one hex digit at a time.
- Drives op1/op2 to the ALU and status outputs to the display path, so operands are no longer fixed constants.
- Sits between the board buttons/switches and the existing ALU, ALU-control and 7-segment display blocks.

---
 rtl/operand_entry_pkg.sv | 16 +
 rtl/operand_entry_btn_debounce.sv | 65 ++++++
 rtl/operand_entry.sv | 122 ++++++++++++
 3 files changed

// File: rtl/operand_entry_pkg.sv
// Shared constants for the operand entry front-end: edit-state encoding,
// button bit positions and the board-level debounce interval.
package operand_entry_pkg;

   typedef enum logic {
      EDIT_OP1 = 1'b0,
      EDIT_OP2 = 1'b1
   } edit_state_t;

   localparam int BTN_ENTER = 0;
   localparam int BTN_NEXT  = 1;

   // 1 ms at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/operand_entry_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing
// samples, and a single-cycle press pulse on the accepted rising edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   // Counter only ever needs to hold 0..DEBOUNCE_CYCLES-1.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_q;
   logic [CNT_W-1:0] r_cnt;

   // Bring the raw pin into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive cycles the synchronized level disagrees with the
   // accepted level; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (r_sync2 != r_level) begin
         if (r_cnt == CNT_TC) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // Delayed accepted level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level_q <= 1'b0;
      end else begin
         r_level_q <= r_level;
      end
   end

   assign level = r_level;
   assign press = r_level & ~r_level_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry front-end for the ALU lab: debounced ENTER/NEXT buttons
// shift switch nibbles into op1/op2 one hex digit at a time.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   EDIT_OP1 | ENTER shifts into op1, sel_op2=0
//   EDIT_OP2 | ENTER shifts into op2, sel_op2=1; 4th digit
//            | pulses load_done and returns to EDIT_OP1
module operand_entry
   import operand_entry_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter logic [15:0] OP1_RESET       = 16'h1122,
   parameter logic [15:0] OP2_RESET       = 16'h3344
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  button,
   input  logic [3:0]  switch,
   output logic [15:0] op1,
   output logic [15:0] op2,
   output logic        sel_op2,
   output logic [1:0]  digit_cnt,
   output logic        load_done
);

   edit_state_t r_state;
   edit_state_t w_state_nxt;
   logic [1:0]  r_cnt;
   logic [1:0]  w_cnt_nxt;
   logic [15:0] r_op1;
   logic [15:0] w_op1_nxt;
   logic [15:0] r_op2;
   logic [15:0] w_op2_nxt;
   logic        r_load_done;
   logic        w_load_nxt;
   logic [3:0]  r_sw_sync1;
   logic [3:0]  r_sw_sync2;
   logic [1:0]  w_press;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_enter (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (button[BTN_ENTER]),
      .level (),
      .press (w_press[BTN_ENTER])
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_next (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (button[BTN_NEXT]),
      .level (),
      .press (w_press[BTN_NEXT])
   );

   // Switches are only synchronized; they are expected to be static
   // by the time a debounced ENTER fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_sync1 <= 4'h0;
         r_sw_sync2 <= 4'h0;
      end else begin
         r_sw_sync1 <= switch;
         r_sw_sync2 <= r_sw_sync1;
      end
   end

   // State, digit counter, operand and load_done registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EDIT_OP1;
         r_cnt       <= 2'd0;
         r_op1       <= OP1_RESET;
         r_op2       <= OP2_RESET;
         r_load_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_op1       <= w_op1_nxt;
         r_op2       <= w_op2_nxt;
         r_load_done <= w_load_nxt;
      end
   end

   // Next-state logic; NEXT takes priority and swallows a coincident ENTER.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_op1_nxt   = r_op1;
      w_op2_nxt   = r_op2;
      w_load_nxt  = 1'b0;
      if (w_press[BTN_NEXT]) begin
         w_state_nxt = (r_state == EDIT_OP1) ? EDIT_OP2 : EDIT_OP1;
         w_cnt_nxt   = 2'd0;
      end else if (w_press[BTN_ENTER]) begin
         if (r_state == EDIT_OP1) begin
            w_op1_nxt = {r_op1[11:0], r_sw_sync2};
         end else begin
            w_op2_nxt = {r_op2[11:0], r_sw_sync2};
         end
         if (r_cnt == 2'd3) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = (r_state == EDIT_OP1) ? EDIT_OP2 : EDIT_OP1;
            w_load_nxt  = (r_state == EDIT_OP2);
         end else begin
            w_cnt_nxt = r_cnt + 2'd1;
         end
      end
   end

   assign op1       = r_op1;
   assign op2       = r_op2;
   assign sel_op2   = (r_state == EDIT_OP2);
   assign digit_cnt = r_cnt;
   assign load_done = r_load_done;

endmodule
